// File: rtl/seg_scan_driver_if.sv
// Value-load handshake between the display value source and the scan engine.
// The source drives value/dp and a one-cycle load strobe; the engine acks on commit.
interface seg_scan_driver_if;
    logic [15:0] value_in;
    logic        value_load;
    logic [3:0]  dp_in;
    logic        load_ack;

    modport master (
        output value_in,
        output value_load,
        output dp_in,
        input  load_ack
    );

    modport slave (
        input  value_in,
        input  value_load,
        input  dp_in,
        output load_ack
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan engine for a 4-digit common-anode 7-segment display.
// Optional PWM brightness control is enabled with the SEG_BRIGHTNESS_EN macro.
module seg_scan_driver #(
    parameter int DIV   = 1000,
    parameter int GUARD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus,
    input  logic [3:0]        blank_in,
    input  logic              lzb_en,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [3:0]        brightness,
`endif
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [1:0]        digit_sel,
    output logic              frame_done
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] pre_cnt;
    logic          tick;
    logic          wrap;
    logic          commit;
    logic [15:0]   disp_val;
    logic [15:0]   shadow_val;
    logic [3:0]    disp_dp;
    logic [3:0]    shadow_dp;
    logic          pending;
    logic [3:0]    nib;
    logic          lead_zero;
    logic          dark;
    logic [6:0]    glyph;
    logic          pwm_ok;
    logic          anode_on;

    assign tick   = (pre_cnt == LAST);
    assign wrap   = tick && (digit_sel == 2'd3);
    assign commit = wrap && pending;

    // Slot prescaler and digit index; the index advances once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            digit_sel <= 2'd0;
        end else if (tick) begin
            pre_cnt   <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            pre_cnt   <= pre_cnt + 1'b1;
        end
    end

    // Shadow capture and frame-boundary commit; a load on the commit edge stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val     <= '0;
            disp_dp      <= '0;
            shadow_val   <= '0;
            shadow_dp    <= '0;
            pending      <= 1'b0;
            bus.load_ack <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (commit) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
            if (bus.value_load) begin
                shadow_val <= bus.value_in;
                shadow_dp  <= bus.dp_in;
                pending    <= 1'b1;
            end else if (commit) begin
                pending    <= 1'b0;
            end
            bus.load_ack <= commit;
            frame_done   <= wrap;
        end
    end

    // Pick the current nibble and decide whether the digit is dark.
    always_comb begin
        nib       = 4'h0;
        lead_zero = 1'b0;
        unique case (digit_sel)
            2'd0: nib = disp_val[3:0];
            2'd1: begin
                nib       = disp_val[7:4];
                lead_zero = (disp_val[15:4] == 12'h000);
            end
            2'd2: begin
                nib       = disp_val[11:8];
                lead_zero = (disp_val[15:8] == 8'h00);
            end
            2'd3: begin
                nib       = disp_val[15:12];
                lead_zero = (disp_val[15:12] == 4'h0);
            end
        endcase
        dark = blank_in[digit_sel] | (lzb_en & lead_zero);
    end

    // Hex to active-low {g,f,e,d,c,b,a} glyph.
    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

`ifdef SEG_BRIGHTNESS_EN
    localparam logic [31:0] DIV_U = 32'(DIV);

    logic [3:0]    phase;
    logic [CW+3:0] scaled;

    assign scaled = {pre_cnt, 4'b0000};

    // PWM phase = floor(pre_cnt*16/DIV) as a ladder of threshold compares.
    always_comb begin
        phase = 4'h0;
        for (int unsigned k = 1; k < 16; k++) begin
            if (32'(scaled) >= k * DIV_U) begin
                phase = 4'(k);
            end
        end
        pwm_ok = (phase <= brightness);
    end
`else
    assign pwm_ok = 1'b1;
`endif

    assign anode_on = (pre_cnt >= GUARD_C) && pwm_ok;

    // Registered pin drivers; dark digits force all cathodes and dp off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= anode_on ? ~(4'b0001 << digit_sel) : 4'hF;
            seg <= dark ? 7'h7F : glyph;
            dp  <= dark | ~disp_dp[digit_sel];
        end
    end

endmodule
